// File: rtl/trigger_capture.sv
// Trigger capture sink: circular pre-trigger history, post-trigger window, replay on a readout stream.
// Define TRIGGER_CAPTURE_EVENT_EN to store sample events alongside data and replay them on sto_tevent.
module trigger_capture #(
    parameter int BAW = 6,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int CAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata,
`ifdef TRIGGER_CAPTURE_EVENT_EN
    output logic [SEW-1:0] sto_tevent,
`endif
    output logic [2:0]     sts_state,
    output logic           sts_err
);

    localparam int DEPTH = 2 ** CAW;
    localparam int LW    = CAW + 1;
`ifdef TRIGGER_CAPTURE_EVENT_EN
    localparam int MW = SDW + SEW;
`else
    localparam int MW = SDW;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_READ  = 3'd3
    } state_t;

    state_t state_q, state_d;

    logic [CAW-1:0] cfg_pre, cfg_post;
    logic [CAW-1:0] act_pre, act_post;
    logic [CAW-1:0] wp, pre_fill, post_cnt;
    logic [LW-1:0]  rd_cnt, len;
    logic [CAW-1:0] rd_addr;
    logic [CAW+1:0] arm_need;
    logic           rd_v, rd_last;
    logic [MW-1:0]  mem [DEPTH];
    logic [MW-1:0]  mem_q;
    logic [MW-1:0]  store_word;

    logic wr_ctrl, wr_pre, wr_post;
    logic bus_abort, bus_arm, arm_fits;
    logic xfer, store, load_out, issue;
    logic unused_bits;

    assign bus_wready = 1'b1;
    assign sts_state  = state_q;
    assign sti_tready = (state_q != S_READ);
    assign xfer       = sti_tvalid && sti_tready;

    assign wr_ctrl   = bus_wvalid && (bus_waddr[1:0] == 2'd0);
    assign wr_pre    = bus_wvalid && (bus_waddr[1:0] == 2'd1);
    assign wr_post   = bus_wvalid && (bus_waddr[1:0] == 2'd2);
    assign bus_abort = wr_ctrl && bus_wdata[1];
    assign bus_arm   = wr_ctrl && bus_wdata[0] && !bus_wdata[1];

    assign arm_need = (CAW+2)'(cfg_pre) + (CAW+2)'(cfg_post) + (CAW+2)'(1);
    assign arm_fits = (arm_need <= (CAW+2)'(DEPTH));

    // The window ends just below wp; rd_cnt walks it oldest-first.
    assign len     = LW'(pre_fill) + LW'(act_post) + LW'(1);
    assign rd_addr = wp - len[CAW-1:0] + rd_cnt[CAW-1:0];

    assign load_out = rd_v && (!sto_tvalid || sto_tready);
    assign issue    = (state_q == S_READ) && !bus_abort && (rd_cnt < len) && (!rd_v || load_out);

`ifdef TRIGGER_CAPTURE_EVENT_EN
    assign store_word = {sti_tevent, sti_tdata};
`else
    assign store_word = sti_tdata;
`endif

    assign unused_bits = ^{bus_waddr[BAW-1:2], bus_wdata[BDW-1:CAW]};

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d = state_q;
        store   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_arm && arm_fits) state_d = S_ARMED;
            end
            S_ARMED, S_POST: begin
                if (bus_abort || (xfer && sti_tevent[1])) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    store = 1'b1;
                    if (state_q == S_ARMED) begin
                        if (sti_tevent[0]) state_d = (act_post == '0) ? S_READ : S_POST;
                    end else if (post_cnt == CAW'(1)) begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus_abort || (sto_tvalid && sto_tready && sto_tlast)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cfg_pre    <= '0;
            cfg_post   <= '0;
            act_pre    <= '0;
            act_post   <= '0;
            wp         <= '0;
            pre_fill   <= '0;
            post_cnt   <= '0;
            rd_cnt     <= '0;
            rd_v       <= 1'b0;
            rd_last    <= 1'b0;
            sto_tvalid <= 1'b0;
            sto_tlast  <= 1'b0;
            sto_tdata  <= '0;
`ifdef TRIGGER_CAPTURE_EVENT_EN
            sto_tevent <= '0;
`endif
            sts_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_pre)  cfg_pre  <= bus_wdata[CAW-1:0];
            if (wr_post) cfg_post <= bus_wdata[CAW-1:0];

            if (state_q == S_IDLE && bus_arm) begin
                if (arm_fits) begin
                    wp       <= '0;
                    pre_fill <= '0;
                    sts_err  <= 1'b0;
                    act_pre  <= cfg_pre;
                    act_post <= cfg_post;
                end else begin
                    sts_err <= 1'b1;
                end
            end

            if (store) begin
                wp <= wp + CAW'(1);
                if (state_q == S_ARMED) begin
                    if (sti_tevent[0])            post_cnt <= act_post;
                    else if (pre_fill != act_pre) pre_fill <= pre_fill + CAW'(1);
                end else begin
                    post_cnt <= post_cnt - CAW'(1);
                end
            end

            if (state_q == S_READ && state_d != S_READ) begin
                rd_cnt     <= '0;
                rd_v       <= 1'b0;
                sto_tvalid <= 1'b0;
                sto_tlast  <= 1'b0;
            end else begin
                if (load_out) begin
                    sto_tvalid <= 1'b1;
                    sto_tlast  <= rd_last;
                    sto_tdata  <= mem_q[SDW-1:0];
`ifdef TRIGGER_CAPTURE_EVENT_EN
                    sto_tevent <= mem_q[MW-1:SDW];
`endif
                end else if (sto_tvalid && sto_tready) begin
                    sto_tvalid <= 1'b0;
                    sto_tlast  <= 1'b0;
                end
                if (issue) begin
                    rd_v    <= 1'b1;
                    rd_last <= (rd_cnt == len - LW'(1));
                    rd_cnt  <= rd_cnt + LW'(1);
                end else if (load_out) begin
                    rd_v <= 1'b0;
                end
            end
        end
    end

    // NOTE: the sample buffer and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (store) mem[wp] <= store_word;
        if (issue) mem_q   <= mem[rd_addr];
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: a window model fills an expected queue, a monitor drains it.
module tb_trigger_capture;
    localparam int BAW = 6, BDW = 32, SDW = 32, SEW = 2, CAW = 4, DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           bus_wready, bus_wvalid = 1'b0;
    logic [BAW-1:0] bus_waddr = '0;
    logic [BDW-1:0] bus_wdata = '0;
    logic           sti_tready, sti_tvalid = 1'b0;
    logic [SEW-1:0] sti_tevent = '0;
    logic [SDW-1:0] sti_tdata = '0;
    logic           sto_tready = 1'b1;
    logic           sto_tvalid, sto_tlast;
    logic [SDW-1:0] sto_tdata;
    logic [2:0]     sts_state;
    logic           sts_err;

    trigger_capture #(.BAW(BAW), .BDW(BDW), .SDW(SDW), .SEW(SEW), .CAW(CAW)) dut (
        .clk(clk), .rst(rst),
        .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
        .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
        .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast), .sto_tdata(sto_tdata),
        .sts_state(sts_state), .sts_err(sts_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    exp_t exp_q[$];
    int errors = 0, checks = 0, pops = 0, rdy_mode = 0;

    // Reference model: mode 0 idle, 1 waiting for trigger, 2 collecting post samples, 3 replaying.
    int m_mode = 0, m_err = 0, m_pre = 0, m_post = 0, m_trig = 0, m_left = 0;
    int cfg_pre_m = 0, cfg_post_m = 0;
    logic [31:0] m_samples[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_window();
        int first;
        first = (m_trig > m_pre) ? m_trig - m_pre : 0;
        for (int i = first; i < m_samples.size(); i++)
            exp_q.push_back('{data: m_samples[i], last: (i == m_samples.size() - 1)});
        m_mode = 3;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_wvalid = 1'b1;
        bus_waddr  = {4'b0, a};
        bus_wdata  = d;
        tick();
        bus_wvalid = 1'b0;
        case (a)
            2'd0: begin
                if (d[1]) begin
                    if (m_mode == 3) exp_q.delete();
                    m_mode = 0;
                end else if (d[0] && m_mode == 0) begin
                    if (cfg_pre_m + cfg_post_m + 1 > DEPTH) m_err = 1;
                    else begin
                        m_err = 0;
                        m_mode = 1;
                        m_pre = cfg_pre_m;
                        m_post = cfg_post_m;
                        m_samples.delete();
                    end
                end
            end
            2'd1: cfg_pre_m  = int'(d) % DEPTH;
            2'd2: cfg_post_m = int'(d) % DEPTH;
            default: ;
        endcase
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] ev);
        check("sti_tready", sti_tready, 1);
        sti_tvalid = 1'b1;
        sti_tdata  = d;
        sti_tevent = ev;
        tick();
        sti_tvalid = 1'b0;
        if (m_mode == 1 || m_mode == 2) begin
            if (ev[1]) m_mode = 0;
            else begin
                m_samples.push_back(d);
                if (m_mode == 1 && ev[0]) begin
                    m_trig = m_samples.size() - 1;
                    m_left = m_post;
                    m_mode = 2;
                end else if (m_mode == 2) begin
                    m_left--;
                end
                if (m_mode == 2 && m_left == 0) finish_window();
            end
        end
        check("state_after_send", sts_state, 64'(m_mode));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || sts_state != 3'd0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_in_time", (n < 300), 1);
        check("idle_after_read", sts_state, 0);
        m_mode = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst && sto_tvalid && sto_tready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h expected no output", sto_tdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", sto_tdata, 64'(e.data));
                check("out_last", sto_tlast, 64'(e.last));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       sto_tready = 1'b1;
            1:       sto_tready = ~sto_tready;
            default: sto_tready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, n;
        #2 rst = 1'b0;
        repeat (3) tick();
        check("rst_state", sts_state, 0);
        check("rst_tvalid", sto_tvalid, 0);
        check("rst_tlast", sto_tlast, 0);
        check("rst_tdata", sto_tdata, 0);
        check("rst_err", sts_err, 0);
        check("rst_wready", bus_wready, 1);
        rst = 1'b1;
        tick();
        check("idle_tready", sti_tready, 1);
        send(32'h55, 2'b01);

        // Window of 3 before and 2 after the trigger.
        bus_write(2'd1, 3);
        bus_write(2'd2, 2);
        bus_write(2'd0, 1);
        check("t1_err", sts_err, 0);
        check("t1_state", sts_state, 1);
        for (int d = 1; d <= 10; d++) send(32'(d), (d == 8) ? 2'b01 : 2'b00);
        check("t1_lat0", sto_tvalid, 0);
        check("t1_sti_blocked", sti_tready, 0);
        tick();
        check("t1_lat1", sto_tvalid, 0);
        tick();
        check("t1_lat2", sto_tvalid, 1);
        wait_drain();

        // Trigger on the very first sample.
        bus_write(2'd0, 1);
        send(32'd1, 2'b01);
        send(32'd2, 2'b00);
        send(32'd3, 2'b00);
        wait_drain();

        // Oversized window is rejected, then accepted once it fits.
        bus_write(2'd1, 10);
        bus_write(2'd2, 6);
        bus_write(2'd0, 1);
        check("t3_err", sts_err, 64'(m_err));
        check("t3_state", sts_state, 64'(m_mode));
        bus_write(2'd2, 5);
        bus_write(2'd0, 1);
        check("t3_err2", sts_err, 64'(m_err));
        check("t3_state2", sts_state, 64'(m_mode));
        bus_write(2'd0, 2);
        check("t3_abort", sts_state, 0);

        // Abort beats trigger on the stream; arm+abort on the bus stays idle.
        bus_write(2'd1, 2);
        bus_write(2'd2, 1);
        bus_write(2'd0, 1);
        send(32'd7, 2'b11);
        bus_write(2'd0, 3);
        check("t4_state", sts_state, 0);
        check("t4_err", sts_err, 0);
        bus_write(2'd0, 1);
        send(32'd40, 2'b01);
        send(32'd41, 2'b00);
        wait_drain();

        // Full-depth window across the buffer wrap.
        bus_write(2'd1, 15);
        bus_write(2'd2, 0);
        bus_write(2'd0, 1);
        for (int d = 1; d <= 20; d++) send(32'(d), (d == 20) ? 2'b01 : 2'b00);
        wait_drain();

        // Back-pressured readout interrupted by reset.
        rdy_mode = 1;
        bus_write(2'd1, 5);
        bus_write(2'd2, 5);
        bus_write(2'd0, 1);
        p0 = pops;
        for (int d = 0; d < 14; d++) send($urandom, (d == 8) ? 2'b01 : 2'b00);
        n = 0;
        while (pops < p0 + 4 && n < 100) begin
            tick();
            n++;
        end
        check("t6_pops_in_time", (n < 100), 1);
        #2 rst = 1'b0;
        exp_q.delete();
        m_mode = 0;
        m_err = 0;
        cfg_pre_m = 0;
        cfg_post_m = 0;
        tick();
        check("t6_rst_tvalid", sto_tvalid, 0);
        check("t6_rst_state", sts_state, 0);
        rst = 1'b1;
        tick();
        check("t6_post_tvalid", sto_tvalid, 0);
        check("t6_post_state", sts_state, 0);
        check("t6_post_tready", sti_tready, 1);

        // Randomized windows, trigger points, aborts and back-pressure.
        rdy_mode = 2;
        for (int it = 0; it < 16; it++) begin
            int pre, post, trig_at, k;
            logic [1:0] ev;
            pre = $urandom_range(0, 12);
            post = $urandom_range(0, 5);
            trig_at = $urandom_range(0, 20);
            bus_write(2'd1, 32'(pre));
            bus_write(2'd2, 32'(post));
            bus_write(2'd0, 1);
            check("rand_err", sts_err, 64'(m_err));
            check("rand_arm_state", sts_state, 64'(m_mode));
            k = 0;
            while ((m_mode == 1 || m_mode == 2) && k < 60) begin
                ev[0] = (m_mode == 1) ? (k >= trig_at) : 1'($urandom_range(0, 1));
                ev[1] = ($urandom_range(0, 29) == 0);
                send($urandom, ev);
                k++;
            end
            if (m_mode == 3) wait_drain();
            check("rand_idle", sts_state, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
